rv32v_strided_mem_sequencer: RTL and testbench

//  Parametrised successor to the fixed 4-lane vector memory serializer in the stage4 MEM stage.

---
 rtl/rv32v_strided_mem_sequencer_if.sv | 51 +++++
 rtl/rv32v_strided_mem_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rv32v_strided_mem_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32v_strided_mem_sequencer_if.sv
// Bundle between the EX/MEM vector register, the load-store controller and the writeback crossbar.
// The master modport is the sequencer's view.
`timescale 1ns/1ps
interface rv32v_strided_mem_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic                        start;
  logic                        is_store;
  logic [1:0]                  mode;
  logic [1:0]                  eew;
  logic [ADDR_W-1:0]           base_addr;
  logic [ADDR_W-1:0]           stride;
  logic [NUM_LANES*ADDR_W-1:0] index;
  logic [NUM_LANES*DATA_W-1:0] store_data;
  logic [NUM_LANES-1:0]        lane_mask;
  logic                        flush;
  logic                        lsc_ready;
  logic                        lsc_error;
  logic [DATA_W-1:0]           lsc_rdata;
  logic                        lsc_ren;
  logic                        lsc_wen;
  logic [ADDR_W-1:0]           lsc_addr;
  logic [DATA_W-1:0]           lsc_wdata;
  logic [1:0]                  lsc_load_type;
  logic [NUM_LANES-1:0]        lane_wen;
  logic [DATA_W-1:0]           lane_data;
  logic                        busy;
  logic                        done;
  logic                        fault;
  logic                        fault_mal;
  logic [LANE_W-1:0]           fault_lane;
  logic [ADDR_W-1:0]           fault_addr;

  modport master (
    input  start, is_store, mode, eew, base_addr, stride, index, store_data, lane_mask, flush,
           lsc_ready, lsc_error, lsc_rdata,
    output lsc_ren, lsc_wen, lsc_addr, lsc_wdata, lsc_load_type, lane_wen, lane_data,
           busy, done, fault, fault_mal, fault_lane, fault_addr
  );

  modport slave (
    output start, is_store, mode, eew, base_addr, stride, index, store_data, lane_mask, flush,
           lsc_ready, lsc_error, lsc_rdata,
    input  lsc_ren, lsc_wen, lsc_addr, lsc_wdata, lsc_load_type, lane_wen, lane_data,
           busy, done, fault, fault_mal, fault_lane, fault_addr
  );
endinterface

// File: rtl/rv32v_strided_mem_sequencer.sv
// Vector memory-op sequencer: walks the active lanes of a unit/strided/indexed access and issues
// one scalar LSC request per element, aborting on misalignment, bus error or flush.
`timescale 1ns/1ps
module rv32v_strided_mem_sequencer #(
  parameter int NUM_LANES   = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SKIP_MASKED = 1
) (
  input logic clk,
  input logic rst,
  rv32v_strided_mem_sequencer_if.master bus
);
  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SKIP  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic                        is_store_r;
  logic [1:0]                  mode_r, eew_r;
  logic [ADDR_W-1:0]           base_r, stride_r;
  logic [NUM_LANES*ADDR_W-1:0] index_r;
  logic [NUM_LANES*DATA_W-1:0] wdata_r;
  logic [NUM_LANES-1:0]        mask_r;
  logic [LANE_W-1:0]           cur_r;
  logic                        fault_mal_r;
  logic [LANE_W-1:0]           fault_lane_r;
  logic [ADDR_W-1:0]           fault_addr_r;

  logic [1:0]                  size_s;
  logic [ADDR_W-1:0]           addr_s;
  logic                        mis_s;
  logic [NUM_LANES-1:0]        rem_s;
  logic                        last_s;
  logic [LANE_W-1:0]           step_s;
  logic                        accept_s, advance_s, fault_set_s, req_s;

  function automatic logic [LANE_W-1:0] first_active(input logic [NUM_LANES-1:0] m);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) r = LANE_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_LANES-1:0] lanes_above(input logic [LANE_W-1:0] c);
    logic [NUM_LANES-1:0] r;
    for (int i = 0; i < NUM_LANES; i++) r[i] = (i > int'(c));
    return r;
  endfunction

  // Element address, alignment check and lane-walk bookkeeping
  always_comb begin
    size_s = (eew_r == 2'd3) ? 2'd2 : eew_r;
    case (mode_r)
      2'd1:    addr_s = base_r + ADDR_W'(cur_r) * stride_r;
      2'd2:    addr_s = base_r + index_r[cur_r*ADDR_W +: ADDR_W];
      default: addr_s = base_r + (ADDR_W'(cur_r) << size_s);
    endcase
    case (size_s)
      2'd1:    mis_s = addr_s[0];
      2'd2:    mis_s = |addr_s[1:0];
      default: mis_s = 1'b0;
    endcase
    rem_s  = mask_r & lanes_above(cur_r);
    last_s = (rem_s == '0);
    // Without skipping, masked lanes are visited one by one through SKIP
    step_s = (SKIP_MASKED != 0) ? first_active(rem_s) : cur_r + LANE_W'(1);
    accept_s    = (state_r == ST_IDLE) && bus.start && !bus.flush;
    advance_s   = !bus.flush && !last_s &&
                  (((state_r == ST_REQ) && !mis_s && bus.lsc_ready && !bus.lsc_error) ||
                   (state_r == ST_SKIP));
    fault_set_s = (state_r == ST_REQ) && !bus.flush &&
                  (mis_s || (bus.lsc_ready && bus.lsc_error));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) state_nxt_s = (bus.lane_mask == '0) ? ST_DONE : ST_REQ;
          else           state_nxt_s = ST_IDLE;
        end
        ST_REQ: begin
          if (mis_s || (bus.lsc_ready && bus.lsc_error)) state_nxt_s = ST_FAULT;
          else if (bus.lsc_ready)
            state_nxt_s = last_s ? ST_DONE : (mask_r[step_s] ? ST_REQ : ST_SKIP);
          else state_nxt_s = ST_REQ;
        end
        ST_SKIP:  state_nxt_s = last_s ? ST_DONE : (mask_r[step_s] ? ST_REQ : ST_SKIP);
        ST_DONE:  state_nxt_s = ST_IDLE;
        ST_FAULT: state_nxt_s = ST_IDLE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Operand latch on an accepted start, lane cursor advance
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_r <= 1'b0;
      mode_r     <= 2'd0;
      eew_r      <= 2'd0;
      base_r     <= '0;
      stride_r   <= '0;
      index_r    <= '0;
      wdata_r    <= '0;
      mask_r     <= '0;
      cur_r      <= '0;
    end else if (accept_s) begin
      is_store_r <= bus.is_store;
      mode_r     <= bus.mode;
      eew_r      <= bus.eew;
      base_r     <= bus.base_addr;
      stride_r   <= bus.stride;
      index_r    <= bus.index;
      wdata_r    <= bus.store_data;
      mask_r     <= bus.lane_mask;
      cur_r      <= first_active(bus.lane_mask);
    end else if (advance_s) begin
      cur_r      <= step_s;
    end
  end

  // Fault cause/lane/address: captured on entry to FAULT, held until the next start
  always_ff @(posedge clk) begin
    if (rst || accept_s) begin
      fault_mal_r  <= 1'b0;
      fault_lane_r <= '0;
      fault_addr_r <= '0;
    end else if (fault_set_s) begin
      fault_mal_r  <= mis_s;
      fault_lane_r <= cur_r;
      fault_addr_r <= addr_s;
    end
  end

  // Output decode
  always_comb begin
    req_s             = (state_r == ST_REQ) && !mis_s && !bus.flush;
    bus.lsc_ren       = req_s && !is_store_r;
    bus.lsc_wen       = req_s && is_store_r;
    bus.lsc_addr      = req_s ? addr_s : '0;
    bus.lsc_wdata     = (req_s && is_store_r) ? wdata_r[cur_r*DATA_W +: DATA_W] : '0;
    bus.lsc_load_type = req_s ? eew_r : 2'd0;
    bus.lane_wen      = '0;
    bus.lane_data     = '0;
    if (bus.lsc_ren && bus.lsc_ready && !bus.lsc_error) begin
      bus.lane_wen[cur_r] = 1'b1;
      bus.lane_data       = bus.lsc_rdata;
    end else begin
      bus.lane_wen        = '0;
    end
    case (state_r)
      ST_IDLE:  bus.busy = bus.start && !bus.flush;
      ST_REQ:   bus.busy = 1'b1;
      ST_SKIP:  bus.busy = 1'b1;
      ST_FAULT: bus.busy = 1'b1;
      default:  bus.busy = 1'b0;
    endcase
    bus.done       = (state_r == ST_DONE) && !bus.flush;
    bus.fault      = (state_r == ST_FAULT) && !bus.flush;
    bus.fault_mal  = fault_mal_r;
    bus.fault_lane = fault_lane_r;
    bus.fault_addr = fault_addr_r;
  end
endmodule

// File: tb/tb_rv32v_strided_mem_sequencer.sv
// Self-checking bench: table of vector memops with expected request streams (scoreboard queue),
// plus hand-written sequences for stalls with bus error, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_rv32v_strided_mem_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rv32v_strided_mem_sequencer_if #(.NUM_LANES(4), .ADDR_W(32), .DATA_W(32)) sif ();

  rv32v_strided_mem_sequencer #(.NUM_LANES(4), .ADDR_W(32), .DATA_W(32), .SKIP_MASKED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  typedef struct packed {
    logic         st;
    logic [1:0]   mode;
    logic [1:0]   eew;
    logic [31:0]  base;
    logic [31:0]  stride;
    logic [127:0] idx;
    logic [3:0]   mask;
    logic [2:0]   n;      // number of requests expected before done/fault
    logic [127:0] addrs;  // expected addresses, first request in the low word
    logic [7:0]   lanes;  // expected lane of each request
    logic         flt;
    logic         mal;
    logic [1:0]   flane;
    logic [31:0]  faddr;
  } vec_t;

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  lane;
  } req_t;

  vec_t vecs [10];
  req_t sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] mode, input logic [1:0] eew,
                              input logic [31:0] base, input logic [31:0] stride,
                              input logic [127:0] idx, input logic [3:0] mask, input logic [2:0] n,
                              input logic [127:0] addrs, input logic [7:0] lanes, input logic flt,
                              input logic mal, input logic [1:0] flane, input logic [31:0] faddr);
    vec_t v;
    v.st = st; v.mode = mode; v.eew = eew; v.base = base; v.stride = stride; v.idx = idx;
    v.mask = mask; v.n = n; v.addrs = addrs; v.lanes = lanes; v.flt = flt; v.mal = mal;
    v.flane = flane; v.faddr = faddr;
    return v;
  endfunction

  task automatic idle_inputs();
    sif.start = 1'b0; sif.is_store = 1'b0; sif.mode = 2'd0; sif.eew = 2'd0;
    sif.base_addr = 32'd0; sif.stride = 32'd0; sif.index = 128'd0; sif.lane_mask = 4'd0;
    sif.flush = 1'b0; sif.lsc_ready = 1'b0; sif.lsc_error = 1'b0; sif.lsc_rdata = 32'd0;
    sif.store_data = {32'hDA7A_0003, 32'hDA7A_0002, 32'hDA7A_0001, 32'hDA7A_0000};
  endtask

  task automatic drive_op(input logic st, input logic [1:0] mode, input logic [1:0] eew,
                          input logic [31:0] base, input logic [31:0] stride,
                          input logic [127:0] idx, input logic [3:0] mask);
    sif.is_store = st; sif.mode = mode; sif.eew = eew; sif.base_addr = base;
    sif.stride = stride; sif.index = idx; sif.lane_mask = mask; sif.start = 1'b1;
  endtask

  task automatic run_op(input int id, input vec_t v);
    req_t        e;
    int          end_iter;
    logic [31:0] rd;
    for (int k = 0; k < int'(v.n); k++) begin
      e.st    = v.st;
      e.addr  = v.addrs[k*32 +: 32];
      e.lane  = v.lanes[k*2 +: 2];
      e.wdata = 32'hDA7A_0000 | {30'd0, e.lane};
      sb_q.push_back(e);
    end
    end_iter = v.flt ? int'(v.n) + 1 : int'(v.n);
    @(negedge clk);
    drive_op(v.st, v.mode, v.eew, v.base, v.stride, v.idx, v.mask);
    sif.lsc_ready = 1'b1; sif.lsc_error = 1'b0;
    #1 chk($sformatf("v%0d_busy_start", id), 32'(sif.busy), 32'd1);
    @(negedge clk);
    sif.start = 1'b0;
    for (int it = 0; it <= end_iter; it++) begin
      rd = 32'hC0DE_0000 | (32'(id) << 8) | 32'(it);
      sif.lsc_rdata = rd;
      #1;
      if (it < int'(v.n)) begin
        chk($sformatf("v%0d_i%0d_ren", id, it), 32'(sif.lsc_ren), 32'(!v.st));
        chk($sformatf("v%0d_i%0d_wen", id, it), 32'(sif.lsc_wen), 32'(v.st));
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d_i%0d_sb_empty", id, it), 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d_i%0d_addr", id, it), sif.lsc_addr, e.addr);
          chk($sformatf("v%0d_i%0d_ltype", id, it), 32'(sif.lsc_load_type), 32'(v.eew));
          if (e.st) begin
            chk($sformatf("v%0d_i%0d_wdata", id, it), sif.lsc_wdata, e.wdata);
            chk($sformatf("v%0d_i%0d_lane_wen", id, it), 32'(sif.lane_wen), 32'd0);
          end else begin
            chk($sformatf("v%0d_i%0d_lane_wen", id, it), 32'(sif.lane_wen), 32'(4'b0001 << e.lane));
            chk($sformatf("v%0d_i%0d_lane_data", id, it), sif.lane_data, rd);
          end
        end
      end else begin
        chk($sformatf("v%0d_i%0d_no_req", id, it), 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
        chk($sformatf("v%0d_i%0d_lane_wen0", id, it), 32'(sif.lane_wen), 32'd0);
      end
      chk($sformatf("v%0d_i%0d_done", id, it), 32'(sif.done), 32'(it == end_iter && !v.flt));
      chk($sformatf("v%0d_i%0d_fault", id, it), 32'(sif.fault), 32'(it == end_iter && v.flt));
      chk($sformatf("v%0d_i%0d_busy", id, it), 32'(sif.busy), 32'(!(it == end_iter && !v.flt)));
      if (it == end_iter && v.flt) begin
        chk($sformatf("v%0d_fault_mal", id), 32'(sif.fault_mal), 32'(v.mal));
        chk($sformatf("v%0d_fault_lane", id), 32'(sif.fault_lane), 32'(v.flane));
        chk($sformatf("v%0d_fault_addr", id), sif.fault_addr, v.faddr);
      end
      @(negedge clk);
    end
    #1;
    chk($sformatf("v%0d_idle_busy", id), 32'(sif.busy), 32'd0);
    chk($sformatf("v%0d_idle_no_req", id), 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
    if (v.flt) begin
      chk($sformatf("v%0d_held_lane", id), 32'(sif.fault_lane), 32'(v.flane));
      chk($sformatf("v%0d_held_addr", id), sif.fault_addr, v.faddr);
    end
    chk($sformatf("v%0d_sb_left", id), 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b0, 2'd0, 2'd2, 32'h100, 32'h0, 128'h0, 4'hF, 3'd4,
                 {32'h10C, 32'h108, 32'h104, 32'h100}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[1] = mk(1'b1, 2'd1, 2'd2, 32'h200, 32'hFFFF_FFF8, 128'h0, 4'h5, 3'd2,
                 {64'h0, 32'h1F0, 32'h200}, {4'h0, 2'd2, 2'd0}, 1'b0, 1'b0, 2'd0, 32'h0);
    // Lane 0 (offset 2) is masked so the misaligned lane 1 is the first element reached
    vecs[2] = mk(1'b0, 2'd2, 2'd2, 32'h300, 32'h0, {32'hC, 32'h0, 32'h6, 32'h2}, 4'hE, 3'd0,
                 128'h0, 8'h0, 1'b1, 1'b1, 2'd1, 32'h306);
    vecs[3] = mk(1'b0, 2'd0, 2'd2, 32'h100, 32'h0, 128'h0, 4'h0, 3'd0,
                 128'h0, 8'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[4] = mk(1'b1, 2'd0, 2'd0, 32'h401, 32'h0, 128'h0, 4'hB, 3'd3,
                 {32'h0, 32'h404, 32'h402, 32'h401}, {2'd0, 2'd3, 2'd1, 2'd0}, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[5] = mk(1'b0, 2'd1, 2'd1, 32'h10, 32'h6, 128'h0, 4'hF, 3'd4,
                 {32'h22, 32'h1C, 32'h16, 32'h10}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[6] = mk(1'b0, 2'd1, 2'd1, 32'h10, 32'h3, 128'h0, 4'hF, 3'd1,
                 {96'h0, 32'h10}, {6'h0, 2'd0}, 1'b1, 1'b1, 2'd1, 32'h13);
    vecs[7] = mk(1'b0, 2'd3, 2'd3, 32'h1000, 32'h0, 128'h0, 4'h9, 3'd2,
                 {64'h0, 32'h100C, 32'h1000}, {4'h0, 2'd3, 2'd0}, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[8] = mk(1'b1, 2'd2, 2'd2, 32'hFFFF_FFFC, 32'h0, {32'h8, 32'h4, 32'h4, 32'h0}, 4'h3, 3'd2,
                 {64'h0, 32'h0, 32'hFFFF_FFFC}, {4'h0, 2'd1, 2'd0}, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[9] = mk(1'b0, 2'd0, 2'd2, 32'h102, 32'h0, 128'h0, 4'h8, 3'd0,
                 128'h0, 8'h0, 1'b1, 1'b1, 2'd3, 32'h10E);

    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy", 32'(sif.busy), 32'd0);
    chk("reset_req", 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
    chk("reset_done_fault", 32'({sif.done, sif.fault}), 32'd0);
    chk("reset_fault_addr", sif.fault_addr, 32'd0);
    chk("reset_fault_lane", 32'(sif.fault_lane), 32'd0);

    for (int v = 0; v < 10; v++) run_op(v, vecs[v]);

    // Lane 0 stalls three cycles, then completes with a bus error
    @(negedge clk);
    drive_op(1'b0, 2'd0, 2'd2, 32'h500, 32'h0, 128'h0, 4'h1);
    sif.lsc_ready = 1'b0; sif.lsc_error = 1'b0;
    @(negedge clk);
    sif.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sif.lsc_ready = (c == 3); sif.lsc_error = (c == 3);
      #1;
      chk($sformatf("stall_c%0d_ren", c), 32'(sif.lsc_ren), 32'd1);
      chk($sformatf("stall_c%0d_addr", c), sif.lsc_addr, 32'h500);
      chk($sformatf("stall_c%0d_lane_wen", c), 32'(sif.lane_wen), 32'd0);
      chk($sformatf("stall_c%0d_fault", c), 32'(sif.fault), 32'd0);
      @(negedge clk);
    end
    sif.lsc_ready = 1'b1; sif.lsc_error = 1'b0;
    #1;
    chk("berr_fault", 32'(sif.fault), 32'd1);
    chk("berr_mal", 32'(sif.fault_mal), 32'd0);
    chk("berr_lane", 32'(sif.fault_lane), 32'd0);
    chk("berr_addr", sif.fault_addr, 32'h500);
    chk("berr_no_req", 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
    @(negedge clk);
    #1;
    chk("berr_idle_busy", 32'(sif.busy), 32'd0);
    chk("berr_held_addr", sif.fault_addr, 32'h500);

    // Flush during lane 2 of a four-lane load
    @(negedge clk);
    drive_op(1'b0, 2'd0, 2'd2, 32'h600, 32'h0, 128'h0, 4'hF);
    sif.lsc_ready = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 chk($sformatf("flush_pre%0d_addr", c), sif.lsc_addr, 32'h600 + 32'(c * 4));
      @(negedge clk);
    end
    sif.flush = 1'b1;
    #1;
    chk("flush_no_req", 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
    chk("flush_no_wb", 32'(sif.lane_wen), 32'd0);
    @(negedge clk);
    sif.flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("flush_post%0d_busy", c), 32'(sif.busy), 32'd0);
      chk($sformatf("flush_post%0d_pulses", c), 32'({sif.done, sif.fault}), 32'd0);
      chk($sformatf("flush_post%0d_req", c), 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
      @(negedge clk);
    end

    // Flush beats start in IDLE
    drive_op(1'b0, 2'd0, 2'd2, 32'h680, 32'h0, 128'h0, 4'hF);
    sif.flush = 1'b1;
    #1 chk("flush_start_busy", 32'(sif.busy), 32'd0);
    @(negedge clk);
    sif.start = 1'b0; sif.flush = 1'b0;
    #1 chk("flush_start_ignored", 32'({sif.lsc_ren, sif.busy}), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    drive_op(1'b0, 2'd0, 2'd2, 32'h700, 32'h0, 128'h0, 4'hF);
    @(negedge clk);
    sif.start = 1'b0;
    #1 chk("rst_pre_ren", 32'(sif.lsc_ren), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'({sif.lsc_ren, sif.lsc_wen}), 32'd0);
    chk("rst_addr", sif.lsc_addr, 32'd0);
    chk("rst_lane_wen", 32'(sif.lane_wen), 32'd0);
    chk("rst_status", 32'({sif.busy, sif.done, sif.fault, sif.fault_mal}), 32'd0);
    chk("rst_fault_regs", sif.fault_addr | 32'(sif.fault_lane), 32'd0);
    @(negedge clk);
    #1 chk("rst_stays_idle", 32'({sif.lsc_ren, sif.busy}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
